dice_roller: RTL and testbench

DICE_ROLLER -- requirements
Module: dice_roller

---
 rtl/dice_pkg.sv | 37 +++
 rtl/button_debounce.sv | 31 +++
 rtl/dice_roller.sv | 150 +++++++++++++++
 tb/tb_dice_roller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types, segment constants and the hex glyph decoder for the dice roller.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SHOW
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low 7-segment glyph, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'b1000000;
      4'h1:    pattern = 7'b1111001;
      4'h2:    pattern = 7'b0100100;
      4'h3:    pattern = 7'b0110000;
      4'h4:    pattern = 7'b0011001;
      4'h5:    pattern = 7'b0010010;
      4'h6:    pattern = 7'b0000010;
      4'h7:    pattern = 7'b1111000;
      4'h8:    pattern = 7'b0000000;
      4'h9:    pattern = 7'b0010000;
      4'hA:    pattern = 7'b0001000;
      4'hB:    pattern = 7'b0000011;
      4'hC:    pattern = 7'b1000110;
      4'hD:    pattern = 7'b0100001;
      4'hE:    pattern = 7'b0000110;
      default: pattern = 7'b0001110;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Level debouncer: the output follows the input only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current output.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout  <= 1'b0;
      count <= '0;
    end else if (din == dout) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      dout  <= din;
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Push-button dice roller: debounced button drives IDLE/ROLL/SHOW, a mixed-radix
// chain of face counters spins while rolling, and the result is shown on 7-seg.
module dice_roller
  import dice_pkg::*;
#(
  parameter int N_DICE          = 2,
  parameter int FACES           = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 button,
  output logic [7*N_DICE-1:0]                  seg,
  output logic                                 rolling,
  output logic                                 result_valid,
  output logic [$clog2(N_DICE*FACES+1)-1:0]    total
);

  localparam int IDX_W   = $clog2(FACES);
  localparam int TOTAL_W = $clog2(N_DICE*FACES+1);
  localparam int QUIET_W = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [IDX_W-1:0]   FACE_LAST  = IDX_W'(FACES - 1);

  generate
    if (N_DICE < 1 || N_DICE > 4) begin : g_bad_n_dice
      $error("dice_roller: N_DICE must be in 1..4");
    end
    if (FACES < 2 || FACES > 15) begin : g_bad_faces
      $error("dice_roller: FACES must be in 2..15");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("dice_roller: DEBOUNCE_CYCLES must be at least 2");
    end
  endgenerate

  logic                         sync_p0;
  logic                         sync_p1;
  logic                         level;
  logic                         level_prev;
  logic                         armed;
  logic [QUIET_W-1:0]           quiet;
  logic                         rise;
  logic                         fall;
  state_t                       state;
  logic [N_DICE-1:0][IDX_W-1:0] idx;
  logic [N_DICE-1:0][IDX_W-1:0] idx_next;
  logic [7*N_DICE-1:0]          seg_show;
  logic [TOTAL_W-1:0]           sum_next;

  // Stage p0/p1: two-flop synchroniser for the raw button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
    end
  end

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (sync_p1),
    .dout (level)
  );

  // A button held through reset must be seen released for longer than the
  // debounce window (plus synchroniser flush) before a press can start a roll.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_prev <= 1'b0;
      quiet      <= '0;
      armed      <= 1'b0;
    end else begin
      level_prev <= level;
      if (sync_p1) begin
        quiet <= '0;
      end else if (quiet != QUIET_LAST) begin
        quiet <= quiet + QUIET_W'(1);
      end
      if (quiet == QUIET_LAST) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = level & ~level_prev & armed;
  assign fall = ~level & level_prev;

  always_comb begin
    logic carry;
    carry    = 1'b1;
    idx_next = idx;
    seg_show = '0;
    sum_next = '0;
    for (int i = 0; i < N_DICE; i++) begin
      if (carry) begin
        idx_next[i] = (idx[i] == FACE_LAST) ? '0 : idx[i] + IDX_W'(1);
      end
      carry = carry & (idx[i] == FACE_LAST);
      seg_show[7*i +: 7] = hex_to_seg(4'(idx_next[i]) + 4'd1);
      sum_next = sum_next + TOTAL_W'(idx_next[i]) + TOTAL_W'(1);
    end
  end

  // The last ROLL cycle's advance is included in the latched result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      rolling      <= 1'b0;
      result_valid <= 1'b0;
      seg          <= {N_DICE{SEG_BLANK}};
      total        <= '0;
    end else begin
      result_valid <= 1'b0;
      if (state == ROLL) begin
        idx <= idx_next;
      end
      case (state)
        IDLE, SHOW: begin
          if (rise) begin
            state   <= ROLL;
            rolling <= 1'b1;
            seg     <= {N_DICE{SEG_DASH}};
          end
        end
        ROLL: begin
          if (fall) begin
            state        <= SHOW;
            rolling      <= 1'b0;
            result_valid <= 1'b1;
            seg          <= seg_show;
            total        <= sum_next;
          end
        end
        default: begin
          state   <= IDLE;
          rolling <= 1'b0;
          seg     <= {N_DICE{SEG_BLANK}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench: three dice_roller configurations share one button and reset;
// each roll pushes the expected face values, a monitor checks them on result_valid.
module tb_dice_roller;

  localparam int DB = 4;

  typedef struct {
    int          total;
    logic [27:0] seg;
    int          len;
  } exp_t;

  localparam logic [6:0] GLY [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button = 1'b0;

  logic [13:0] seg_a;
  logic        rolling_a, rv_a;
  logic [3:0]  total_a;
  logic [6:0]  seg_b;
  logic        rolling_b, rv_b;
  logic [3:0]  total_b;
  logic [6:0]  seg_c;
  logic        rolling_c, rv_c;
  logic [2:0]  total_c;

  int n_checks = 0;
  int n_fail = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  int roll_len_a = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  exp_t e_a, e_b, e_c;

  always #5 clk = ~clk;

  dice_roller #(.N_DICE(2), .FACES(6), .DEBOUNCE_CYCLES(DB)) dut_a (
    .clk(clk), .reset(reset), .button(button),
    .seg(seg_a), .rolling(rolling_a), .result_valid(rv_a), .total(total_a));

  dice_roller #(.N_DICE(1), .FACES(15), .DEBOUNCE_CYCLES(DB)) dut_b (
    .clk(clk), .reset(reset), .button(button),
    .seg(seg_b), .rolling(rolling_b), .result_valid(rv_b), .total(total_b));

  dice_roller #(.N_DICE(1), .FACES(6), .DEBOUNCE_CYCLES(DB)) dut_c (
    .clk(clk), .reset(reset), .button(button),
    .seg(seg_c), .rolling(rolling_c), .result_valid(rv_c), .total(total_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: result_valid with no roll outstanding at %0t", name, $time);
  endtask

  // Mixed-radix model: die i shows digit i of the roll count in base f, plus one.
  function automatic exp_t model(input int cnt, input int n, input int f, input int h);
    exp_t e;
    int rem;
    int d;
    rem     = cnt;
    e.total = 0;
    e.seg   = '0;
    e.len   = h;
    for (int i = 0; i < n; i++) begin
      d = rem % f;
      rem = rem / f;
      e.total += d + 1;
      e.seg[7*i +: 7] = GLY[d+1];
    end
    return e;
  endfunction

  task automatic roll(input int h);
    @(posedge clk);
    #1 button = 1'b1;
    repeat (h) @(posedge clk);
    #1 button = 1'b0;
    cnt_a += h;
    cnt_b += h;
    cnt_c += h;
    q_a.push_back(model(cnt_a, 2, 6, h));
    q_b.push_back(model(cnt_b, 1, 15, h));
    q_c.push_back(model(cnt_c, 1, 6, h));
    repeat (DB + 12) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      roll_len_a = 0;
    end else begin
      if (rolling_a) roll_len_a++;
      if (rv_a) begin
        if (q_a.size() == 0) flag_unexpected("rv_a");
        else begin
          e_a = q_a.pop_front();
          check("total_a", 32'(total_a), 32'(e_a.total));
          check("seg_a", 32'(seg_a), 32'(e_a.seg));
          check("roll_len_a", 32'(roll_len_a), 32'(e_a.len));
          roll_len_a = 0;
        end
      end
      if (rv_b) begin
        if (q_b.size() == 0) flag_unexpected("rv_b");
        else begin
          e_b = q_b.pop_front();
          check("total_b", 32'(total_b), 32'(e_b.total));
          check("seg_b", 32'(seg_b), 32'(e_b.seg));
        end
      end
      if (rv_c) begin
        if (q_c.size() == 0) flag_unexpected("rv_c");
        else begin
          e_c = q_c.pop_front();
          check("total_c", 32'(total_c), 32'(e_c.total));
          check("seg_c", 32'(seg_c), 32'(e_c.seg));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("reset_seg_a", 32'(seg_a), 32'h3FFF);
    check("reset_total_a", 32'(total_a), 0);
    check("reset_rolling_a", 32'(rolling_a), 0);
    check("reset_rv_a", 32'(rv_a), 0);
    check("reset_seg_b", 32'(seg_b), 32'h7F);
    check("reset_total_b", 32'(total_b), 0);
    check("reset_seg_c", 32'(seg_c), 32'h7F);
    check("reset_total_c", 32'(total_c), 0);
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // Glitch one cycle shorter than the debounce window
    #1 button = 1'b1;
    repeat (DB - 1) @(posedge clk);
    #1 button = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_rolling_a", 32'(rolling_a), 0);
    check("glitch_seg_a", 32'(seg_a), 32'h3FFF);
    check("glitch_seg_b", 32'(seg_b), 32'h7F);

    // 13 roll cycles: single d6 shows 2
    roll(13);
    #1;
    check("hold_total_c", 32'(total_c), 2);
    check("hold_seg_c", 32'(seg_c), 32'(7'b0100100));

    // 15 rolls of 16 cycles step the d15 through every face and across its wrap
    for (int r = 0; r < 15; r++) roll(16);

    // Reset in the middle of a roll, with the button still held afterwards
    @(posedge clk);
    #1 button = 1'b1;
    k = 0;
    while (!rolling_a && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("roll_start_a", 32'(rolling_a), 1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midroll_rolling_a", 32'(rolling_a), 0);
    check("midroll_total_a", 32'(total_a), 0);
    check("midroll_seg_a", 32'(seg_a), 32'h3FFF);
    check("midroll_total_b", 32'(total_b), 0);
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("held_after_reset_rolling_a", 32'(rolling_a), 0);
    check("held_after_reset_seg_a", 32'(seg_a), 32'h3FFF);
    button = 1'b0;
    repeat (20) @(posedge clk);

    // 6 roll cycles from zero: die 0 back to index 0, die 1 at index 1
    roll(6);
    #1;
    check("six_total_a", 32'(total_a), 3);
    check("six_seg_a", 32'(seg_a), 32'({GLY[2], GLY[1]}));

    repeat (20) @(posedge clk);
    check("pending_a", 32'(q_a.size()), 0);
    check("pending_b", 32'(q_b.size()), 0);
    check("pending_c", 32'(q_c.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
